ltl_report_collector: RTL

- Downstream stage of an LTL monitor automaton cluster.
- Samples the cluster's report-STE outputs on every run cycle.
- For each cycle with any report active, captures a record {symbol offset, report vector, symbol} into a FIFO.
- Drains records to the checker/host over a valid/ready interface; tracks overflow.

---
 rtl/ltl_report_pkg.sv | 15 +
 rtl/ltl_report_collector_if.sv | 29 ++
 rtl/ltl_report_fifo.sv | 65 ++++++
 rtl/ltl_report_collector.sv | 118 +++++++++++
 4 files changed

// File: rtl/ltl_report_pkg.sv
// Shared constants and the default record layout for the LTL report collector.
package ltl_report_pkg;

    localparam int NUM_REPORTS_DEFAULT = 4;
    localparam int OFFSET_W_DEFAULT    = 32;
    localparam int DROP_CNT_W          = 16;
    localparam int SYMBOL_W            = 8;

    typedef struct packed {
        logic [OFFSET_W_DEFAULT-1:0]    offset;
        logic [NUM_REPORTS_DEFAULT-1:0] report;
        logic [SYMBOL_W-1:0]            symbol;
    } report_rec_t;

endpackage

// File: rtl/ltl_report_collector_if.sv
// Record drain bus: the collector is the master (producer), the checker/host the slave.
interface ltl_report_collector_if
    import ltl_report_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEFAULT,
    parameter int OFFSET_W    = OFFSET_W_DEFAULT
);
    logic                   out_valid;
    logic                   out_ready;
    logic [OFFSET_W-1:0]    out_offset;
    logic [NUM_REPORTS-1:0] out_report;
    logic [SYMBOL_W-1:0]    out_symbol;

    modport master (
        output out_valid,
        output out_offset,
        output out_report,
        output out_symbol,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_offset,
        input  out_report,
        input  out_symbol,
        output out_ready
    );
endinterface

// File: rtl/ltl_report_fifo.sv
// Synchronous FIFO of report records with flush; head is presented from the storage array.
module ltl_report_fifo
    import ltl_report_pkg::*;
#(
    parameter type rec_t = report_rec_t,
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  rec_t                   wdata,
    output rec_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    rec_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (level == DEPTH_L);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers and the rdata gate hide stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/ltl_report_collector.sv
// Captures {offset, report vector, symbol} on every reporting run cycle and drains them over out_if.
// Optional: define REPORT_DEDUP_EN to record only onsets/changes of the report vector.
module ltl_report_collector
    import ltl_report_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEFAULT,
    parameter int DEPTH       = 8,
    parameter int OFFSET_W    = OFFSET_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic [SYMBOL_W-1:0]      symbols,
    input  logic [NUM_REPORTS-1:0]   report_in,
    input  logic                     clear,
    ltl_report_collector_if.master   out_if,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic [$clog2(DEPTH):0]   level
);
    typedef struct packed {
        logic [OFFSET_W-1:0]    offset;
        logic [NUM_REPORTS-1:0] report;
        logic [SYMBOL_W-1:0]    symbol;
    } rec_t;

    localparam logic [OFFSET_W-1:0]   OFF_ONE  = {{(OFFSET_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  is_new;
    logic                  capture;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    rec_t                  wr_rec;
    rec_t                  rd_rec;

`ifdef REPORT_DEDUP_EN
    logic [NUM_REPORTS-1:0] last_report_q, last_report_d;

    // Tracks every run cycle, including silent ones, so a repeat after a gap is a fresh onset.
    always_comb begin
        last_report_d = last_report_q;
        if (clear)    last_report_d = '0;
        else if (run) last_report_d = report_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) last_report_q <= '0;
        else          last_report_q <= last_report_d;
    end

    assign is_new = (report_in != last_report_q);
`else
    assign is_new = 1'b1;
`endif

    assign capture = run && (|report_in) && is_new;
    assign pop     = !fifo_empty && out_if.out_ready;
    assign drop    = capture && fifo_full && !pop;
    assign wr_rec  = '{offset: offset_q, report: report_in, symbol: symbols};

    ltl_report_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .push    (capture),
        .pop     (out_if.out_ready),
        .wdata   (wr_rec),
        .rdata   (rd_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        offset_d   = offset_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            offset_d   = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (run) offset_d = offset_q + OFF_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            offset_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            offset_q   <= offset_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign out_if.out_valid  = !fifo_empty;
    assign out_if.out_offset = rd_rec.offset;
    assign out_if.out_report = rd_rec.report;
    assign out_if.out_symbol = rd_rec.symbol;
    assign overflow          = overflow_q;
    assign drop_count        = drop_q;
endmodule
